// File: rtl/glove_pkg.sv
// glove_pkg: shared TX FSM encoding, WAIT timeout and index helper
package glove_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} tx_state_e;
  localparam int WAIT_CYCLES = 4;
  localparam int WAIT_W = $clog2(WAIT_CYCLES);
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/tx_event_arbiter_sync_fifo.sv
// sync_fifo: power-of-two circular buffer with occupancy count
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && level != LW'(DEPTH);
  assign do_pop = pop && level != '0;
  assign dout = mem[rd_ptr];
  // storage write; contents need no reset since level gates every read
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
endmodule

// File: rtl/tx_event_arbiter.sv
// tx_event_arbiter: round-robin event collector feeding a paced UART byte sender
module tx_event_arbiter
  import glove_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      uart_ready,
  output logic                      uart_send,
  output logic [DATA_W-1:0]         uart_data,
  input  logic                      rts,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);
  localparam int RW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  logic [RW-1:0] rr, sel, idx;
  logic found, full, push, pop;
  logic [DATA_W-1:0] head;
  tx_state_e state, state_next;
  logic [WAIT_W-1:0] cnt;
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(req_data[int'(sel)*DATA_W +: DATA_W]),
    .dout(head),
    .level(level)
  );
  // first active requester at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = RW'(wrap_idx(int'(rr), k, NUM_REQ));
      if (!found && req[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  assign full = level == LW'(DEPTH);
  assign push = rst && found && !full;
  assign req_ack = push ? NUM_REQ'(1) << sel : '0;
  // pointer advances only on an accepted grant; a rejected request marks overflow
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) rr <= RW'(wrap_idx(int'(sel), 1, NUM_REQ));
      if (found && full) overflow <= 1'b1;
    end
  // sender state, WAIT dwell counter and the held output byte
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      uart_data <= '0;
    end else begin
      state <= state_next;
      cnt <= state == WAIT ? cnt + WAIT_W'(1) : '0;
      if (pop) uart_data <= head;
    end
  // start a byte only when idle, data queued, UART ready and peer not holding off
  always_comb begin
    pop = state == IDLE && level != '0 && uart_ready && !rts;
    state_next = pop ? SEND
               : state == SEND ? WAIT
               : state == WAIT && (!uart_ready || cnt == WAIT_W'(WAIT_CYCLES - 1)) ? IDLE
               : state;
  end
  assign uart_send = state == SEND;
endmodule

// File: tb/tb_tx_event_arbiter.sv
// tb_tx_event_arbiter: vector table plus directed sequences for the event arbiter
module tb_tx_event_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] req = '0, req_ack, level;
  logic [31:0] req_data = '0;
  logic uart_ready = 1'b1, uart_send, rts = 1'b0, overflow;
  logic [7:0] uart_data;
  int checks = 0, fails = 0;

  typedef struct {
    logic rst;
    logic [3:0] req;
    logic [31:0] data;
    logic [3:0] ack;
    logic send;
    logic [7:0] udata;
    logic [3:0] lvl;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  tx_event_arbiter #(.NUM_REQ(4), .DATA_W(8), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .req_ack(req_ack),
    .uart_ready(uart_ready),
    .uart_send(uart_send),
    .uart_data(uart_data),
    .rts(rts),
    .level(level),
    .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [31:0] d,
                              input logic [3:0] a, input logic s, input logic [7:0] u,
                              input logic [3:0] l);
    vec_t v;
    v.rst = r; v.req = rq; v.data = d; v.ack = a; v.send = s; v.udata = u; v.lvl = l;
    return v;
  endfunction

  task automatic push(input int i, input logic [7:0] code);
    @(negedge clk);
    req = 4'(1 << i);
    req_data[i*8 +: 8] = code;
    #1 chk("push_ack", req_ack, 32'(4'(1 << i)));
    @(posedge clk);
    #1 req = '0;
  endtask

  task automatic drain(input int n, input logic [7:0] first, input int gap, input bit drop);
    int got = 0, last = 0, cyc = 0;
    bit seen = 1'b0;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      uart_ready = drop ? !seen : 1'b1;
      #1 seen = uart_send;
      if (seen) begin
        chk("drain_byte", 32'(uart_data), 32'(first) + got);
        if (got > 0) chk("drain_gap", cyc - last, gap);
        last = cyc;
        got++;
      end
      cyc++;
    end
    uart_ready = 1'b1;
    chk("drain_count", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vq.push_back(mk(1, 4'h2, 32'h0000_0300, 4'h2, 0, 8'h00, 0));
    vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 8'h00, 1));
    vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 1, 8'h03, 0));
    vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 8'h03, 0));
    vq.push_back(mk(0, 4'hF, 32'h0302_0100, 4'h0, 0, 8'h00, 0));
    vq.push_back(mk(0, 4'h0, 32'h0, 4'h0, 0, 8'h00, 0));
    vq.push_back(mk(1, 4'hF, 32'h0302_0100, 4'h1, 0, 8'h00, 0));
    vq.push_back(mk(1, 4'hE, 32'h0302_0100, 4'h2, 0, 8'h00, 1));
    vq.push_back(mk(1, 4'hC, 32'h0302_0100, 4'h4, 1, 8'h00, 1));
    vq.push_back(mk(1, 4'h8, 32'h0302_0100, 4'h8, 0, 8'h00, 2));
    for (int k = 0; k < 4; k++) vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 8'h00, 3));
    vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 1, 8'h01, 2));
    for (int k = 0; k < 5; k++) vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 8'h01, 2));
    vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 1, 8'h02, 1));
    for (int k = 0; k < 5; k++) vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 8'h02, 1));
    vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 1, 8'h03, 0));
    for (int k = 0; k < 5; k++) vq.push_back(mk(1, 4'h0, 32'h0, 4'h0, 0, 8'h03, 0));

    #1;
    chk("reset_level", 32'(level), 0);
    chk("reset_send", 32'(uart_send), 0);
    chk("reset_ack", 32'(req_ack), 0);
    chk("reset_data", 32'(uart_data), 0);
    chk("reset_ovf", 32'(overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clk);
      rst = vq[n].rst;
      req = vq[n].req;
      req_data = vq[n].data;
      #1;
      chk($sformatf("row%0d_ack", n), 32'(req_ack), 32'(vq[n].ack));
      chk($sformatf("row%0d_send", n), 32'(uart_send), 32'(vq[n].send));
      chk($sformatf("row%0d_data", n), 32'(uart_data), 32'(vq[n].udata));
      chk($sformatf("row%0d_level", n), 32'(level), 32'(vq[n].lvl));
      chk($sformatf("row%0d_ovf", n), 32'(overflow), 0);
    end
    @(negedge clk);
    req = '0;
    rst = 1'b1;

    rts = 1'b1;
    for (int k = 0; k < 8; k++) push(0, 8'(8'h10 + k));
    chk("full_level", 32'(level), 8);
    @(negedge clk);
    req = 4'h1;
    req_data[7:0] = 8'h18;
    #1 chk("ninth_ack", 32'(req_ack), 0);
    @(posedge clk);
    #1;
    chk("ninth_ovf", 32'(overflow), 1);
    chk("ninth_level", 32'(level), 8);
    chk("ninth_send", 32'(uart_send), 0);
    @(negedge clk);
    rts = 1'b0;
    #1;
    chk("full_pop_ack", 32'(req_ack), 0);
    chk("full_pop_level_before", 32'(level), 8);
    @(posedge clk);
    #1 req = '0;
    chk("full_pop_level_after", 32'(level), 7);
    drain(8, 8'h10, 6, 1'b0);
    chk("drain_level", 32'(level), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);

    rts = 1'b1;
    for (int k = 0; k < 6; k++) push(2, 8'(8'h20 + k));
    chk("abort_fill_level", 32'(level), 6);
    @(negedge clk);
    rts = 1'b0;
    @(posedge clk);
    #1 rts = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_send", 32'(uart_send), 1);
    chk("abort_data", 32'(uart_data), 32'h20);
    chk("abort_level", 32'(level), 5);
    @(posedge clk);
    #1;
    chk("abort_wait_send", 32'(uart_send), 0);
    chk("abort_wait_level", 32'(level), 5);
    rst = 1'b0;
    rts = 1'b0;
    #1;
    chk("in_reset_level", 32'(level), 0);
    chk("in_reset_send", 32'(uart_send), 0);
    chk("in_reset_ovf", 32'(overflow), 0);
    chk("in_reset_data", 32'(uart_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("post_reset_send", 32'(uart_send), 0);
      chk("post_reset_level", 32'(level), 0);
      chk("post_reset_ovf", 32'(overflow), 0);
    end

    rts = 1'b1;
    push(0, 8'h41);
    push(0, 8'h42);
    rts = 1'b0;
    drain(2, 8'h41, 3, 1'b1);
    chk("fast_level", 32'(level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/tx_event_arbiter.md
TX_EVENT_ARBITER -- requirements
Module: tx_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of event requesters.
REQ-002 SHALL have parameter DATA_W, default 8, event code width (one UART byte).
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, single clock domain, rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, NUM_REQ, per-requester event valid.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_W, event codes; requester i uses bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ack, output, NUM_REQ, one-hot accept pulse.
REQ-009 SHALL have port uart_ready, input, 1, UART transmitter idle.
REQ-010 SHALL have port uart_send, output, 1, one-cycle transmit strobe.
REQ-011 SHALL have port uart_data, output, DATA_W, byte for the UART; held stable from the send strobe until the next strobe.
REQ-012 SHALL have port rts, input, 1, peer flow control; high means hold off.
REQ-013 SHALL have port level, output, $clog2(DEPTH)+1, FIFO occupancy.
REQ-014 SHALL have port overflow, output, 1, sticky flag for any req cycle rejected while the FIFO is full.

Function
REQ-015 SHALL hold a requester's req high with req_data stable until its req_ack; a request is accepted only in the cycle req_ack is high.
REQ-016 SHALL grant at most one requester per cycle, round-robin, starting the search at the index after the last granted one (index 0 after reset).
REQ-017 SHALL assert req_ack[i] combinationally in the grant cycle only when level < DEPTH; the entry is written at that clock edge.
REQ-018 SHALL reject all requests when level == DEPTH, even if a pop occurs in the same cycle; in that case no ack, overflow is set to 1, and the round-robin pointer does not move.
REQ-019 SHALL keep the FIFO order equal to the acceptance order; read and write pointers wrap modulo DEPTH.
REQ-020 SHALL update level on a simultaneous push and pop: unchanged.
REQ-021 SHALL use a TX FSM with states IDLE, SEND, WAIT.
REQ-022 SHALL go IDLE to SEND when level > 0, uart_ready is 1 and rts is 0; uart_data is loaded with the FIFO head and the entry is popped on that edge.
REQ-023 SHALL assert uart_send = 1 for exactly the one cycle spent in SEND; SEND always moves to WAIT.
REQ-024 SHALL leave WAIT for IDLE on the first cycle uart_ready is 0, or after 4 cycles in WAIT, whichever comes first. This guards against a UART whose ready drops late.
REQ-025 SHALL not start a new byte while rts is 1; a byte already strobed is not recalled.
REQ-026 SHALL give a minimum byte-to-byte spacing of 3 cycles, strobe to strobe.
REQ-027 SHALL never underflow: no pop when level == 0.

Reset
REQ-028 SHALL, while rst is low: FSM=IDLE, pointers=0, level=0, RR pointer=0, uart_send=0, uart_data=0, req_ack=0, overflow=0.
REQ-029 SHALL treat reset asserted mid-transfer as a full abort: FIFO contents are discarded and no send strobe occurs during reset or in the first cycle after release.
REQ-030 SHALL clear overflow only by reset.

Structure
REQ-031 SHALL place the TX FSM state encoding and the WAIT timeout constant (4) in shared package glove_pkg.
REQ-032 SHALL implement the storage as sub-module sync_fifo (parameters DATA_W, DEPTH; ports push, pop, din, dout, level); arbitration and the FSM live in tx_event_arbiter.

Verification
REQ-033 SHALL cover: req[1]=1 with code 0x03 on an idle UART -> req_ack[1] pulses once, then uart_send pulses with uart_data=0x03.
REQ-034 SHALL cover: req=4'b1111 held for 4 acks, codes 0x00..0x03, last grant index 3 -> ack order 0,1,2,3 and bytes sent 0x00,0x01,0x02,0x03.
REQ-035 SHALL cover: rts=1, push 8 events, then push a ninth -> level=8, no ack for the ninth, overflow=1, uart_send stays 0; after rts=0 all 8 bytes drain in order and level returns to 0.
REQ-036 SHALL cover: full FIFO with a pop in the same cycle as a request -> request rejected, level becomes 7.
REQ-037 SHALL cover: uart_ready tied to 1 -> sends are spaced 6 cycles apart (the 4-cycle WAIT timeout applies).
REQ-038 SHALL cover: rst low for 2 cycles with 5 entries queued and the FSM in WAIT -> level=0, uart_send=0 and overflow=0 after release.
